tlk2711_rx_buf_sched: RTL and testbench

Receive-side buffer scheduler for the TLK2711 RX link. It places received frames into a ring of `NUM_BUF` DDR frame buffers. It issues the link's start pulse and base address for each buffer, counts frame-complete interrupts, and tracks how many filled buffers the host has not yet released. On a link or sync loss it drains the link's RX FIFO and pulses the link's soft reset. The block sits between the host register file and the RX link, on the same clock as the link.

---
 rtl/tlk2711_rx_buf_sched.sv | 178 +++++++++++++++++
 tb/tb_tlk2711_rx_buf_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_rx_buf_sched.sv
// Receive buffer scheduler for the TLK2711 RX link: walks a ring of DDR frame
// buffers, tracks host-owned buffers, and recovers the link after loss of sync.
module tlk2711_rx_buf_sched #(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_BUF     = 4,
  parameter int DRAIN_MAX   = 4096,
  parameter int SRST_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_enable,
  input  logic [ADDR_WIDTH-1:0]      i_base_addr,
  input  logic [ADDR_WIDTH-1:0]      i_buf_stride,
  input  logic [15:0]                i_frames_per_buf,
  input  logic                       i_buf_release,
  input  logic                       i_rx_interrupt,
  input  logic                       i_loss_interrupt,
  input  logic                       i_rx_fifo_empty,
  output logic                       o_rx_start,
  output logic [ADDR_WIDTH-1:0]      o_rx_base_addr,
  output logic                       o_rx_fifo_rd,
  output logic                       o_soft_rst,
  output logic                       o_buf_done,
  output logic [$clog2(NUM_BUF)-1:0] o_buf_idx,
  output logic [$clog2(NUM_BUF):0]   o_full_cnt,
  output logic [15:0]                o_loss_cnt,
  output logic                       o_drain_timeout,
  output logic [2:0]                 o_state
);

  localparam int IDX_W = $clog2(NUM_BUF);
  localparam int CNT_W = IDX_W + 1;
  localparam int DRN_W = $clog2(DRAIN_MAX + 1);
  localparam int SRC_W = $clog2(SRST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_RUN      = 3'd2,
    S_WAIT_BUF = 3'd3,
    S_DRAIN    = 3'd4,
    S_SRST     = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]        full_cnt_q, full_cnt_d;
  logic [15:0]             loss_cnt_q, loss_cnt_d;
  logic [DRN_W-1:0]        drain_cnt_q, drain_cnt_d;
  logic [SRC_W-1:0]        srst_cnt_q, srst_cnt_d;
  logic [ADDR_WIDTH-1:0]   base_addr_q, base_addr_d;
  logic                    buf_done_q, buf_done_d;
  logic [IDX_W-1:0]        buf_idx_q, buf_idx_d;
  logic                    timeout_q, timeout_d;
  logic [15:0]             fpb_eff;
  logic                    done;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    frame_cnt_d = frame_cnt_q;
    full_cnt_d  = full_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    drain_cnt_d = drain_cnt_q;
    srst_cnt_d  = srst_cnt_q;
    base_addr_d = base_addr_q;
    buf_done_d  = 1'b0;
    buf_idx_d   = buf_idx_q;
    timeout_d   = timeout_q;
    done        = 1'b0;
    fpb_eff     = (i_frames_per_buf == 16'd0) ? 16'd1 : i_frames_per_buf;

    unique case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_START;
      end
      S_START: begin
        frame_cnt_d = '0;
        state_d     = S_RUN;
      end
      S_RUN, S_WAIT_BUF: begin
        if (i_rx_interrupt) frame_cnt_d = frame_cnt_q + 16'd1;
        // Loss wins over a same-cycle completion; the frame is still counted.
        if (i_loss_interrupt || !i_enable) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
          if (i_loss_interrupt && loss_cnt_q != 16'hFFFF) loss_cnt_d = loss_cnt_q + 16'd1;
        end else if (state_q == S_RUN) begin
          if (i_rx_interrupt && (({1'b0, frame_cnt_q} + 17'd1) >= {1'b0, fpb_eff})) begin
            done    = 1'b1;
            state_d = S_WAIT_BUF;
          end
        end else if (full_cnt_q < CNT_W'(NUM_BUF)) begin
          state_d = S_START;
        end
      end
      S_DRAIN: begin
        if (i_rx_fifo_empty) begin
          state_d    = S_SRST;
          srst_cnt_d = '0;
        end else if (drain_cnt_q == DRN_W'(DRAIN_MAX - 1)) begin
          state_d    = S_SRST;
          srst_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_SRST: begin
        frame_cnt_d = '0;
        if (srst_cnt_q == SRC_W'(SRST_CYCLES - 1)) begin
          state_d = i_enable ? S_START : S_IDLE;
        end else begin
          srst_cnt_d = srst_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      buf_done_d = 1'b1;
      buf_idx_d  = wr_idx_q;
      wr_idx_d   = wr_idx_q + 1'b1;
    end

    if (done && !i_buf_release) begin
      full_cnt_d = full_cnt_q + 1'b1;
    end else if (!done && i_buf_release && full_cnt_q != '0) begin
      full_cnt_d = full_cnt_q - 1'b1;
    end

    // Address is latched as START is entered, using the post-completion index.
    if (state_d == S_START) begin
      base_addr_d = i_base_addr + ADDR_WIDTH'(wr_idx_d) * i_buf_stride;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_idx_q    <= '0;
      frame_cnt_q <= '0;
      full_cnt_q  <= '0;
      loss_cnt_q  <= '0;
      drain_cnt_q <= '0;
      srst_cnt_q  <= '0;
      base_addr_q <= '0;
      buf_done_q  <= 1'b0;
      buf_idx_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      frame_cnt_q <= frame_cnt_d;
      full_cnt_q  <= full_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      srst_cnt_q  <= srst_cnt_d;
      base_addr_q <= base_addr_d;
      buf_done_q  <= buf_done_d;
      buf_idx_q   <= buf_idx_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_rx_start      = (state_q == S_START);
  assign o_rx_base_addr  = base_addr_q;
  assign o_rx_fifo_rd    = (state_q == S_DRAIN) && !i_rx_fifo_empty;
  assign o_soft_rst      = (state_q == S_SRST);
  assign o_buf_done      = buf_done_q;
  assign o_buf_idx       = buf_idx_q;
  assign o_full_cnt      = full_cnt_q;
  assign o_loss_cnt      = loss_cnt_q;
  assign o_drain_timeout = timeout_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_tlk2711_rx_buf_sched.sv
// Bench for tlk2711_rx_buf_sched: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_tlk2711_rx_buf_sched;

  localparam int NB = 4;
  localparam int DMAX = 4096;
  localparam int SRC = 4;
  localparam int IDLE = 0, START = 1, RUN = 2, WAITB = 3, DRAIN = 4, SRST = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable, i_buf_release, i_rx_interrupt, i_loss_interrupt, i_rx_fifo_empty;
  logic [31:0] i_base_addr, i_buf_stride;
  logic [15:0] i_frames_per_buf;
  logic        o_rx_start, o_rx_fifo_rd, o_soft_rst, o_buf_done, o_drain_timeout;
  logic [31:0] o_rx_base_addr;
  logic [1:0]  o_buf_idx;
  logic [2:0]  o_full_cnt, o_state;
  logic [15:0] o_loss_cnt;

  int checks = 0;
  int errors = 0;

  tlk2711_rx_buf_sched #(.ADDR_WIDTH(32), .NUM_BUF(NB), .DRAIN_MAX(DMAX), .SRST_CYCLES(SRC)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_base_addr(i_base_addr),
    .i_buf_stride(i_buf_stride), .i_frames_per_buf(i_frames_per_buf),
    .i_buf_release(i_buf_release), .i_rx_interrupt(i_rx_interrupt),
    .i_loss_interrupt(i_loss_interrupt), .i_rx_fifo_empty(i_rx_fifo_empty),
    .o_rx_start(o_rx_start), .o_rx_base_addr(o_rx_base_addr), .o_rx_fifo_rd(o_rx_fifo_rd),
    .o_soft_rst(o_soft_rst), .o_buf_done(o_buf_done), .o_buf_idx(o_buf_idx),
    .o_full_cnt(o_full_cnt), .o_loss_cnt(o_loss_cnt), .o_drain_timeout(o_drain_timeout),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks the scheduler's observable situation per cycle.
  int          m_state, m_wr, m_frames, m_full, m_loss, m_drain_cycles, m_srst_left, m_idx;
  bit          m_timeout, m_done;
  logic [31:0] m_base;

  task automatic model_begin_buffer();
    m_state = START;
    m_base  = 32'(i_base_addr + 32'(m_wr) * i_buf_stride);
  endtask

  task automatic model_step();
    int  target;
    bit  completed;
    int  full_before;
    target      = (i_frames_per_buf == 16'd0) ? 1 : int'(i_frames_per_buf);
    completed   = 1'b0;
    full_before = m_full;
    m_done      = 1'b0;
    case (m_state)
      IDLE:  if (i_enable) model_begin_buffer();
      START: begin m_frames = 0; m_state = RUN; end
      RUN, WAITB: begin
        if (i_rx_interrupt) m_frames = m_frames + 1;
        if (i_loss_interrupt || !i_enable) begin
          if (i_loss_interrupt) m_loss = (m_loss == 65535) ? 65535 : m_loss + 1;
          m_state = DRAIN;
          m_drain_cycles = 0;
        end else if (m_state == RUN) begin
          if (i_rx_interrupt && m_frames >= target) begin
            completed = 1'b1;
            m_state   = WAITB;
          end
        end else if (full_before < NB) begin
          model_begin_buffer();
        end
      end
      DRAIN: begin
        m_drain_cycles = m_drain_cycles + 1;
        if (i_rx_fifo_empty) begin
          m_state = SRST; m_srst_left = SRC;
        end else if (m_drain_cycles == DMAX) begin
          m_state = SRST; m_srst_left = SRC; m_timeout = 1'b1;
        end
      end
      SRST: begin
        m_frames    = 0;
        m_srst_left = m_srst_left - 1;
        if (m_srst_left == 0) begin
          if (i_enable) model_begin_buffer();
          else m_state = IDLE;
        end
      end
      default: m_state = IDLE;
    endcase
    if (completed) begin
      m_done = 1'b1;
      m_idx  = m_wr;
      m_wr   = (m_wr + 1) % NB;
    end
    // Net occupancy: +1 per completion, -1 per honoured release.
    m_full = m_full + int'(completed);
    if (i_buf_release && (full_before > 0 || completed)) m_full = m_full - 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = IDLE; m_wr = 0; m_frames = 0; m_full = 0; m_loss = 0;
      m_drain_cycles = 0; m_srst_left = 0; m_idx = 0; m_timeout = 1'b0;
      m_done = 1'b0; m_base = 32'h0;
    end else begin
      model_step();
    end
  end

  // Single compare point, away from the active edge.
  always @(negedge clk) begin
    chk("state", 64'(o_state), 64'(m_state));
    chk("rx_start", 64'(o_rx_start), 64'(m_state == START));
    chk("base_addr", 64'(o_rx_base_addr), 64'(m_base));
    chk("fifo_rd", 64'(o_rx_fifo_rd), 64'((m_state == DRAIN) && !i_rx_fifo_empty));
    chk("soft_rst", 64'(o_soft_rst), 64'(m_state == SRST));
    chk("buf_done", 64'(o_buf_done), 64'(m_done));
    if (m_done) chk("buf_idx", 64'(o_buf_idx), 64'(m_idx));
    chk("full_cnt", 64'(o_full_cnt), 64'(m_full));
    chk("loss_cnt", 64'(o_loss_cnt), 64'(m_loss));
    chk("drain_timeout", 64'(o_drain_timeout), 64'(m_timeout));
  end

  // Event logs used by the directed scenarios.
  logic [31:0] starts[$];
  int          done_idx[$];
  int          rd_cycles = 0, srst_cycles = 0, drain_cycles = 0;
  always @(negedge clk) begin
    if (o_rx_start) starts.push_back(o_rx_base_addr);
    if (o_buf_done) done_idx.push_back(int'(o_buf_idx));
    if (o_rx_fifo_rd) rd_cycles++;
    if (o_soft_rst) srst_cycles++;
    if (o_state == 3'(DRAIN)) drain_cycles++;
  end

  task automatic wait_state(input int s, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (int'(o_state) == s) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_state timeout waiting for state %0d, actual=%0d", s, o_state);
  endtask

  task automatic irq_in_run();
    wait_state(RUN, 50);
    #1 i_rx_interrupt = 1'b1;
    @(negedge clk);
    #1 i_rx_interrupt = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int rd0, srst0, dr0;

  initial begin
    rst_n = 1'b0; i_enable = 1'b0; i_buf_release = 1'b0; i_rx_interrupt = 1'b0;
    i_loss_interrupt = 1'b0; i_rx_fifo_empty = 1'b1;
    i_base_addr = 32'h1000_0000; i_buf_stride = 32'h0010_0000; i_frames_per_buf = 16'd3;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'(o_state), 64'd0);
    chk("reset_full", 64'(o_full_cnt), 64'd0);
    chk("reset_base", 64'(o_rx_base_addr), 64'd0);
    #1 rst_n = 1'b1;

    // Basic fill: enable and 9 frames at 3 frames per buffer.
    @(negedge clk); #1 i_enable = 1'b1;
    @(negedge clk);
    chk("enable_to_start", 64'(o_rx_start), 64'd1);
    for (int i = 0; i < 9; i++) irq_in_run();
    @(negedge clk);
    chk("fill_start0", 64'(starts[0]), 64'h1000_0000);
    chk("fill_start1", 64'(starts[1]), 64'h1010_0000);
    chk("fill_start2", 64'(starts[2]), 64'h1020_0000);
    chk("fill_idx0", 64'(done_idx[0]), 64'd0);
    chk("fill_idx1", 64'(done_idx[1]), 64'd1);
    chk("fill_idx2", 64'(done_idx[2]), 64'd2);
    chk("fill_full", 64'(o_full_cnt), 64'd3);

    // Ring full, then one release wraps to buffer 0.
    for (int i = 0; i < 3; i++) irq_in_run();
    @(negedge clk);
    chk("ring_state_wait", 64'(o_state), 64'd3);
    chk("ring_full", 64'(o_full_cnt), 64'd4);
    chk("ring_idx3", 64'(done_idx[3]), 64'd3);
    #1 i_buf_release = 1'b1;
    @(negedge clk);
    chk("release_full", 64'(o_full_cnt), 64'd3);
    chk("release_still_wait", 64'(o_state), 64'd3);
    #1 i_buf_release = 1'b0;
    @(negedge clk);
    chk("release_start", 64'(o_rx_start), 64'd1);
    chk("release_wrap_addr", 64'(o_rx_base_addr), 64'h1000_0000);

    // Loss during RUN with five FIFO words to discard.
    wait_state(RUN, 20);
    rd0 = rd_cycles; srst0 = srst_cycles;
    #1 i_rx_fifo_empty = 1'b0; i_loss_interrupt = 1'b1;
    @(negedge clk);
    chk("loss_drain", 64'(o_state), 64'd4);
    #1 i_loss_interrupt = 1'b0;
    repeat (4) @(negedge clk);
    #1 i_rx_fifo_empty = 1'b1;
    wait_state(RUN, 30);
    chk("loss_rd_cycles", 64'(rd_cycles - rd0), 64'd5);
    chk("loss_srst_cycles", 64'(srst_cycles - srst0), 64'd4);
    chk("loss_restart_addr", 64'(starts[$]), 64'h1000_0000);
    chk("loss_cnt1", 64'(o_loss_cnt), 64'd1);

    // Release coinciding with a buffer completion.
    irq_in_run(); irq_in_run();
    wait_state(RUN, 20);
    #1 i_rx_interrupt = 1'b1; i_buf_release = 1'b1;
    @(negedge clk);
    chk("simul_done", 64'(o_buf_done), 64'd1);
    chk("simul_full", 64'(o_full_cnt), 64'd3);
    #1 i_rx_interrupt = 1'b0; i_buf_release = 1'b0;

    // Loss and frame interrupt in the same cycle.
    wait_state(RUN, 20);
    #1 i_rx_interrupt = 1'b1; i_loss_interrupt = 1'b1;
    @(negedge clk);
    chk("loss_irq_state", 64'(o_state), 64'd4);
    chk("loss_irq_cnt", 64'(o_loss_cnt), 64'd2);
    chk("loss_irq_nodone", 64'(o_buf_done), 64'd0);
    #1 i_rx_interrupt = 1'b0; i_loss_interrupt = 1'b0;

    // Drain timeout: disable with a FIFO that never empties.
    wait_state(RUN, 30);
    #1 i_rx_fifo_empty = 1'b0; i_enable = 1'b0;
    dr0 = drain_cycles;
    wait_state(SRST, DMAX + 100);
    chk("timeout_drain_cycles", 64'(drain_cycles - dr0), 64'(DMAX));
    chk("timeout_flag", 64'(o_drain_timeout), 64'd1);
    chk("timeout_no_loss", 64'(o_loss_cnt), 64'd2);
    #1 i_rx_fifo_empty = 1'b1;
    wait_state(IDLE, 20);

    // Randomized traffic against the model.
    for (int run = 0; run < 3; run++) begin
      #1;
      i_frames_per_buf = 16'($urandom_range(0, 3));
      i_base_addr      = $urandom & 32'hFFFF_F000;
      i_buf_stride     = 32'($urandom_range(1, 255)) << 12;
      for (int c = 0; c < 1000; c++) begin
        i_enable         = ($urandom_range(0, 99) < 97);
        i_rx_interrupt   = ($urandom_range(0, 99) < 40);
        i_loss_interrupt = ($urandom_range(0, 99) < 2);
        i_buf_release    = ($urandom_range(0, 99) < 25);
        i_rx_fifo_empty  = ($urandom_range(0, 99) < 80);
        @(negedge clk);
        #1;
      end
    end
    i_rx_interrupt = 1'b0; i_loss_interrupt = 1'b0; i_buf_release = 1'b0;
    i_rx_fifo_empty = 1'b1; i_enable = 1'b1;
    i_base_addr = 32'h2000_0000; i_buf_stride = 32'h100;

    // Asynchronous reset in the middle of RUN.
    wait_state(RUN, 100);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_state", 64'(o_state), 64'd0);
    chk("areset_outputs", 64'({o_rx_start, o_rx_fifo_rd, o_soft_rst, o_buf_done, o_drain_timeout}), 64'd0);
    chk("areset_counts", 64'({o_full_cnt, o_loss_cnt, o_buf_idx}), 64'd0);
    chk("areset_base", 64'(o_rx_base_addr), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    wait_state(START, 10);
    chk("areset_restart_addr", 64'(o_rx_base_addr), 64'h2000_0000);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
